// File: rtl/parking_keypad_entry_if.sv
// parking_keypad_entry_if
//   Keypad/controller-side signal bundle for one gate's keypad entry front end.
//   master : the keypad scanner / sensor / controller side (drives strobes).
//   slave  : the parking_keypad_entry block (drives password and status).
//   Signals:
//     sensor_entry   car present at gate (level)
//     key_valid      one-cycle digit strobe, key_code sampled with it
//     key_code[3:0]  hex digit
//     key_enter      one-cycle enter strobe
//     key_clear      one-cycle clear strobe
//     pw_reject      one-cycle wrong-password indication from controller
//     password[15:0] assembled password, first digit in [15:12]
//     password_valid one-cycle strobe
//     digit_count    digits entered so far (0..4)
//     entry_error    one-cycle pulse, enter with fewer than 4 digits
//     timeout        one-cycle pulse, inactivity abort
//     locked         high while locked out
interface parking_keypad_entry_if;
    logic        sensor_entry;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_enter;
    logic        key_clear;
    logic        pw_reject;
    logic [15:0] password;
    logic        password_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;
    logic        locked;

    modport master (
        output sensor_entry, key_valid, key_code, key_enter, key_clear, pw_reject,
        input  password, password_valid, digit_count, entry_error, timeout, locked
    );

    modport slave (
        input  sensor_entry, key_valid, key_code, key_enter, key_clear, pw_reject,
        output password, password_valid, digit_count, entry_error, timeout, locked
    );
endinterface

// File: rtl/parking_keypad_entry.sv
// parking_keypad_entry
//   Collects four hex digits per entry attempt at one gate and presents a
//   16-bit password with a one-cycle valid strobe. Armed by the entry sensor;
//   handles clear, short-entry errors, inactivity timeout and sensor abort.
//   Optional macro ATTEMPT_LOCKOUT_EN adds a reject counter that forces a
//   timed lockout after MAX_REJECTS consecutive controller rejects.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   kb   parking_keypad_entry_if.slave (keys/sensor in, password/status out)
// Parameters:
//   TIMEOUT_CYCLES  inactivity limit in COLLECT (>=2)
//   LOCKOUT_CYCLES  lockout duration (macro builds only)
//   MAX_REJECTS     consecutive rejects that trigger lockout (macro builds only)
module parking_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 5000,
    parameter int MAX_REJECTS    = 3
) (
    input logic                  clk,
    input logic                  rst,
    parking_keypad_entry_if.slave kb
);

    typedef enum logic [2:0] {IDLE, COLLECT, SEND, WAIT_CLEAR, LOCKOUT} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter hits T-2 on the last quiet cycle; the registered pulse then
    // appears as the count would reach T-1.
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

    state_t         state;
    logic [15:0]    sr;
    logic [2:0]     cnt;
    logic [TW-1:0]  tcnt;
    logic [15:0]    pw_q;
    logic           pv_q;
    logic           err_q;
    logic           to_q;

`ifdef ATTEMPT_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_REJECTS + 1);
    localparam logic [LW-1:0] L_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_REJECTS);

    logic [LW-1:0]  lcnt;
    logic [RW-1:0]  rej_cnt;
    logic           sent;      // at least one SEND since last clear
    logic           rej_seen;  // a reject arrived since the most recent SEND
    logic           lock_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            pw_q  <= '0;
            pv_q  <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
`ifdef ATTEMPT_LOCKOUT_EN
            lcnt     <= '0;
            rej_cnt  <= '0;
            sent     <= 1'b0;
            rej_seen <= 1'b0;
            lock_q   <= 1'b0;
`endif
        end else begin
            pv_q  <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
`ifdef ATTEMPT_LOCKOUT_EN
            if (kb.pw_reject && state != LOCKOUT && rej_cnt != R_MAX) begin
                rej_cnt  <= rej_cnt + 1'b1;
                rej_seen <= 1'b1;
            end
            // Reject threshold pre-empts whatever the FSM was doing.
            if (state != LOCKOUT && rej_cnt == R_MAX) begin
                state  <= LOCKOUT;
                lock_q <= 1'b1;
                lcnt   <= '0;
                sr     <= '0;
                cnt    <= '0;
                tcnt   <= '0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (kb.sensor_entry) begin
                            state <= COLLECT;
                            sr    <= '0;
                            cnt   <= '0;
                            tcnt  <= '0;
                            pw_q  <= '0;
                        end
                    end
                    COLLECT: begin
                        if (!kb.sensor_entry) begin
                            state <= IDLE;
                            sr    <= '0;
                            cnt   <= '0;
                            tcnt  <= '0;
                        end else if (kb.key_clear) begin
                            sr   <= '0;
                            cnt  <= '0;
                            tcnt <= '0;
                        end else if (kb.key_enter) begin
                            tcnt <= '0;
                            cnt  <= '0;
                            if (cnt == 3'd4) begin
                                pw_q  <= sr;
                                pv_q  <= 1'b1;
                                state <= SEND;
`ifdef ATTEMPT_LOCKOUT_EN
                                // A previous SEND that drew no reject breaks the streak.
                                if (sent && !rej_seen)
                                    rej_cnt <= '0;
                                sent     <= 1'b1;
                                rej_seen <= 1'b0;
`endif
                            end else begin
                                err_q <= 1'b1;
                                sr    <= '0;
                            end
                        end else if (kb.key_valid) begin
                            tcnt <= '0;
                            if (cnt != 3'd4) begin
                                sr  <= {sr[11:0], kb.key_code};
                                cnt <= cnt + 3'd1;
                            end
                        end else if (tcnt == T_LAST) begin
                            to_q  <= 1'b1;
                            state <= IDLE;
                            sr    <= '0;
                            cnt   <= '0;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    SEND: begin
                        state <= WAIT_CLEAR;
                    end
                    WAIT_CLEAR: begin
                        if (!kb.sensor_entry)
                            state <= IDLE;
                    end
`ifdef ATTEMPT_LOCKOUT_EN
                    LOCKOUT: begin
                        if (lcnt == L_LAST) begin
                            state    <= IDLE;
                            lock_q   <= 1'b0;
                            rej_cnt  <= '0;
                            sent     <= 1'b0;
                            rej_seen <= 1'b0;
                        end else begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kb.password       = pw_q;
    assign kb.password_valid = pv_q;
    assign kb.digit_count    = cnt;
    assign kb.entry_error    = err_q;
    assign kb.timeout        = to_q;

`ifdef ATTEMPT_LOCKOUT_EN
    assign kb.locked = lock_q;
`else
    logic unused_pw_reject;
    assign unused_pw_reject = kb.pw_reject;
    assign kb.locked        = 1'b0;
`endif

endmodule

// File: tb/tb_parking_keypad_entry.sv
module tb_parking_keypad_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    parking_keypad_entry_if kb();

    parking_keypad_entry #(
        .TIMEOUT_CYCLES(20),
        .LOCKOUT_CYCLES(50),
        .MAX_REJECTS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kb(kb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        kb.key_valid = 1'b1;
        kb.key_code  = d;
        step();
        kb.key_valid = 1'b0;
    endtask

    task automatic enter();
        kb.key_enter = 1'b1;
        step();
        kb.key_enter = 1'b0;
    endtask

    task automatic clear();
        kb.key_clear = 1'b1;
        step();
        kb.key_clear = 1'b0;
    endtask

    // Drop sensor long enough to reach IDLE from SEND/WAIT_CLEAR/COLLECT, then arm.
    task automatic rearm();
        kb.sensor_entry = 1'b0;
        step();
        step();
        kb.sensor_entry = 1'b1;
        step();
    endtask

    initial begin
        kb.sensor_entry = 1'b0;
        kb.key_valid    = 1'b0;
        kb.key_code     = 4'h0;
        kb.key_enter    = 1'b0;
        kb.key_clear    = 1'b0;
        kb.pw_reject    = 1'b0;
        step();
        step();
        chk("rst_pw",    32'(kb.password), 32'h0);
        chk("rst_pv",    32'(kb.password_valid), 0);
        chk("rst_dc",    32'(kb.digit_count), 0);
        chk("rst_err",   32'(kb.entry_error), 0);
        chk("rst_to",    32'(kb.timeout), 0);
        chk("rst_lock",  32'(kb.locked), 0);
        rst = 1'b0;

        // Basic four-digit entry
        kb.sensor_entry = 1'b1;
        step();
        press(4'h1); chk("dc1", 32'(kb.digit_count), 1);
        press(4'h2); chk("dc2", 32'(kb.digit_count), 2);
        press(4'h3); chk("dc3", 32'(kb.digit_count), 3);
        press(4'h4); chk("dc4", 32'(kb.digit_count), 4);
        enter();
        chk("pv_1234", 32'(kb.password_valid), 1);
        chk("pw_1234", 32'(kb.password), 32'h1234);
        chk("dc_after_send", 32'(kb.digit_count), 0);
        step();
        chk("pv_one_cycle", 32'(kb.password_valid), 0);
        chk("pw_hold", 32'(kb.password), 32'h1234);

        // WAIT_CLEAR ignores keys; sensor must drop before re-arm
        press(4'h7);
        chk("wc_key_ignored", 32'(kb.digit_count), 0);
        enter();
        chk("wc_enter_ignored", 32'(kb.password_valid), 0);
        rearm();
        chk("arm_clears_pw", 32'(kb.password), 32'h0);

        // Short entry error, then good entry
        press(4'h5);
        press(4'h6);
        enter();
        chk("err_pulse", 32'(kb.entry_error), 1);
        chk("err_no_pv", 32'(kb.password_valid), 0);
        chk("err_dc", 32'(kb.digit_count), 0);
        step();
        chk("err_one_cycle", 32'(kb.entry_error), 0);
        press(4'hA); press(4'hB); press(4'hC); press(4'hD);
        enter();
        chk("pw_abcd", 32'(kb.password), 32'hABCD);
        chk("pv_abcd", 32'(kb.password_valid), 1);

        // Fifth digit ignored
        rearm();
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
        chk("dc_sat", 32'(kb.digit_count), 4);
        enter();
        chk("pw_9876", 32'(kb.password), 32'h9876);

        // Clear mid-entry
        rearm();
        press(4'h1); press(4'h2);
        clear();
        chk("clear_dc", 32'(kb.digit_count), 0);
        press(4'h4); press(4'h3); press(4'h2); press(4'h1);
        enter();
        chk("pw_4321", 32'(kb.password), 32'h4321);

        // Clear and enter together: clear wins
        rearm();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        kb.key_clear = 1'b1;
        kb.key_enter = 1'b1;
        step();
        kb.key_clear = 1'b0;
        kb.key_enter = 1'b0;
        chk("ce_no_pv", 32'(kb.password_valid), 0);
        chk("ce_dc", 32'(kb.digit_count), 0);
        chk("ce_no_err", 32'(kb.entry_error), 0);

        // Inactivity timeout: key, then 19 quiet cycles
        press(4'h1);
        repeat (18) step();
        chk("to_early", 32'(kb.timeout), 0);
        step();
        chk("to_pulse", 32'(kb.timeout), 1);
        chk("to_dc", 32'(kb.digit_count), 0);
        press(4'h5); // sampled in IDLE -> ignored, arms COLLECT
        chk("to_one_cycle", 32'(kb.timeout), 0);
        chk("to_idle_key_ignored", 32'(kb.digit_count), 0);

        // Sensor drop mid-entry aborts silently
        press(4'h3); press(4'h4);
        chk("abort_pre_dc", 32'(kb.digit_count), 2);
        kb.sensor_entry = 1'b0;
        step();
        chk("abort_dc", 32'(kb.digit_count), 0);
        chk("abort_no_err", 32'(kb.entry_error), 0);
        chk("abort_no_pv", 32'(kb.password_valid), 0);
        step();
        chk("abort_no_to", 32'(kb.timeout), 0);
        kb.sensor_entry = 1'b1;
        step();
        press(4'h8);
        chk("rearm_dc", 32'(kb.digit_count), 1);

`ifdef ATTEMPT_LOCKOUT_EN
        for (int r = 0; r < 3; r++) begin
            rearm();
            press(4'h1); press(4'h1); press(4'h1); press(4'h1);
            enter();
            kb.pw_reject = 1'b1;
            step();
            kb.pw_reject = 1'b0;
        end
        chk("lock_not_yet", 32'(kb.locked), 0);
        step();
        chk("lock_on", 32'(kb.locked), 1);
        for (int i = 0; i < 48; i++) begin
            kb.key_valid = 1'b1;
            kb.key_code  = 4'h2;
            step();
        end
        kb.key_valid = 1'b0;
        step();
        chk("lock_held", 32'(kb.locked), 1);
        chk("lock_keys_ignored", 32'(kb.digit_count), 0);
        step();
        chk("lock_off", 32'(kb.locked), 0);
        step();
        press(4'h6);
        chk("post_lock_dc", 32'(kb.digit_count), 1);
`else
        for (int r = 0; r < 3; r++) begin
            rearm();
            press(4'h1); press(4'h1); press(4'h1); press(4'h1);
            enter();
            kb.pw_reject = 1'b1;
            step();
            kb.pw_reject = 1'b0;
        end
        step();
        chk("no_lock", 32'(kb.locked), 0);
        rearm();
        press(4'h6);
        chk("no_lock_dc", 32'(kb.digit_count), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
